// File: rtl/periph_fifo_port_pkg.sv
// Shared register map, bit positions and helpers for the periph_fifo_port
// peripheral (CPU <-> stream bridge through two FIFOs).
package periph_fifo_port_pkg;

  typedef enum logic [1:0] {
    OFF_CTRL   = 2'd0,
    OFF_STAT   = 2'd1,
    OFF_TXDATA = 2'd2,
    OFF_RXDATA = 2'd3
  } reg_off_e;

  localparam int CTRL_TXIE    = 0;
  localparam int CTRL_RXIE    = 1;
  localparam int CTRL_TXFLUSH = 2;
  localparam int CTRL_RXFLUSH = 3;

  localparam int STAT_TXFULL  = 0;
  localparam int STAT_TXEMPTY = 1;
  localparam int STAT_RXFULL  = 2;
  localparam int STAT_RXEMPTY = 3;
  localparam int STAT_RXOVF   = 4;
  localparam int STAT_TXOVF   = 5;

  // Disabled byte lanes are replaced by zero rather than kept from a prior value.
  function automatic logic [15:0] byte_mask(input logic [15:0] d, input logic [1:0] be);
    byte_mask = {(be[1] ? d[15:8] : 8'h00), (be[0] ? d[7:0] : 8'h00)};
  endfunction

endpackage

// File: rtl/periph_fifo_buf.sv
// Generic synchronous FIFO with combinational head, flush and occupancy count.
// Full/empty gating uses pre-edge state; flush overrides push and pop.
module periph_fifo_buf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  // Head is forced to zero when empty so stale storage never leaks out.
  assign dout_o = empty_o ? '0 : mem[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + PW'(1);
      if (pop_ok)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_q] <= din_i;
  end

endmodule

// File: rtl/periph_fifo_port.sv
// Memory-mapped TX/RX FIFO peripheral on the per_* bus.
// PERIPH_FIFO_IRQ_EN enables the TXIE/RXIE bits and the irq_fifo level output.
module periph_fifo_port
  import periph_fifo_port_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h40,
  parameter int         DEPTH     = 4
) (
  input  logic        mclk,
  input  logic        puc,
  input  logic [7:0]  per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_wen,
  output logic [15:0] per_dout,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        irq_fifo
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          sel, wr, rd;
  reg_off_e      off;
  logic          ctrl_wr, stat_wr;
  logic          tx_flush, rx_flush;
  logic          tx_push, tx_pop, rx_pop;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [15:0]   rx_head;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_ovf_q, rx_ovf_d;
  logic [15:0]   ctrl_rd, stat_rd;

  assign sel = per_en & (per_addr[7:2] == BASE_ADDR[7:2]);
  assign wr  = sel & (|per_wen);
  assign rd  = sel & ~(|per_wen);
  assign off = reg_off_e'(per_addr[1:0]);

  // All CTRL/STAT writable bits live in the low byte.
  assign ctrl_wr  = wr & (off == OFF_CTRL) & per_wen[0];
  assign stat_wr  = wr & (off == OFF_STAT) & per_wen[0];
  assign tx_flush = ctrl_wr & per_din[CTRL_TXFLUSH];
  assign rx_flush = ctrl_wr & per_din[CTRL_RXFLUSH];
  assign tx_push  = wr & (off == OFF_TXDATA);
  assign rx_pop   = rd & (off == OFF_RXDATA);
  assign tx_pop   = tx_valid & tx_ready;

  periph_fifo_buf #(.DEPTH(DEPTH), .WIDTH(16)) u_tx_fifo (
    .clk_i   (mclk),
    .rst_i   (puc),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .flush_i (tx_flush),
    .din_i   (byte_mask(per_din, per_wen)),
    .dout_o  (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_cnt)
  );

  periph_fifo_buf #(.DEPTH(DEPTH), .WIDTH(16)) u_rx_fifo (
    .clk_i   (mclk),
    .rst_i   (puc),
    .push_i  (rx_valid),
    .pop_i   (rx_pop),
    .flush_i (rx_flush),
    .din_i   (rx_data),
    .dout_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_cnt)
  );

  assign tx_valid = ~tx_empty;

  // A dropped push sets OVF even if software clears it in the same cycle;
  // a push dropped because of a flush is not an overflow.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    if (stat_wr & per_din[STAT_TXOVF]) tx_ovf_d = 1'b0;
    if (stat_wr & per_din[STAT_RXOVF]) rx_ovf_d = 1'b0;
    if (tx_push & tx_full & ~tx_flush) tx_ovf_d = 1'b1;
    if (rx_valid & rx_full & ~rx_flush) rx_ovf_d = 1'b1;
  end

  always_ff @(posedge mclk or posedge puc) begin
    if (puc) begin
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
    end
  end

`ifdef PERIPH_FIFO_IRQ_EN
  logic txie_q, txie_d;
  logic rxie_q, rxie_d;

  always_comb begin
    txie_d = txie_q;
    rxie_d = rxie_q;
    if (ctrl_wr) begin
      txie_d = per_din[CTRL_TXIE];
      rxie_d = per_din[CTRL_RXIE];
    end
  end

  always_ff @(posedge mclk or posedge puc) begin
    if (puc) begin
      txie_q <= 1'b0;
      rxie_q <= 1'b0;
    end else begin
      txie_q <= txie_d;
      rxie_q <= rxie_d;
    end
  end

  assign ctrl_rd  = {14'h0000, rxie_q, txie_q};
  assign irq_fifo = (txie_q & tx_empty) | (rxie_q & ~rx_empty);
`else
  assign ctrl_rd  = 16'h0000;
  assign irq_fifo = 1'b0;
`endif

  always_comb begin
    stat_rd                = 16'h0000;
    stat_rd[STAT_TXFULL]   = tx_full;
    stat_rd[STAT_TXEMPTY]  = tx_empty;
    stat_rd[STAT_RXFULL]   = rx_full;
    stat_rd[STAT_RXEMPTY]  = rx_empty;
    stat_rd[STAT_RXOVF]    = rx_ovf_q;
    stat_rd[STAT_TXOVF]    = tx_ovf_q;
    stat_rd[11:8]          = 4'(tx_cnt);
    stat_rd[15:12]         = 4'(rx_cnt);
  end

  always_comb begin
    per_dout = 16'h0000;
    if (rd) begin
      case (off)
        OFF_CTRL:   per_dout = ctrl_rd;
        OFF_STAT:   per_dout = stat_rd;
        OFF_TXDATA: per_dout = 16'h0000;
        OFF_RXDATA: per_dout = rx_head;
        default:    per_dout = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_fifo_port.sv
// Scoreboard bench for periph_fifo_port: TX words queued on CPU push and
// compared on each tx handshake; RX words queued on rx_valid and compared on CPU reads.
module tb_periph_fifo_port;

  localparam logic [7:0] BASE  = 8'h40;
  localparam int         DEPTH = 4;
`ifdef PERIPH_FIFO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        mclk = 1'b0;
  logic        puc = 1'b1;
  logic [7:0]  per_addr = 8'h00;
  logic [15:0] per_din = 16'h0000;
  logic        per_en = 1'b0;
  logic [1:0]  per_wen = 2'b00;
  logic [15:0] per_dout;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] rx_data = 16'h0000;
  logic        rx_valid = 1'b0;
  logic        irq_fifo;

  int total = 0;
  int bad = 0;

  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  bit txovf_m = 0, rxovf_m = 0, txie_m = 0, rxie_m = 0;

  periph_fifo_port #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .mclk(mclk), .puc(puc), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_wen(per_wen), .per_dout(per_dout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .irq_fifo(irq_fifo)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s val=%h", tag, got);
    end
  endtask

  function automatic logic [15:0] exp_stat();
    logic [15:0] s;
    s = {4'(rx_q.size()), 4'(tx_q.size()), 2'b00, txovf_m, rxovf_m,
         rx_q.size() == 0, rx_q.size() == DEPTH, tx_q.size() == 0, tx_q.size() == DEPTH};
    return s;
  endfunction

  function automatic logic exp_irq();
    return IRQ_EN & ((txie_m & (tx_q.size() == 0)) | (rxie_m & (rx_q.size() != 0)));
  endfunction

  // TX scoreboard: the word at the head must match at every handshake.
  always @(negedge mclk) begin
    if (!puc && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) check("tx_extra", {15'h0, tx_valid}, 16'h0000);
      else check("tx_pop", tx_data, tx_q.pop_front());
    end
  end

  // One bus cycle starting just after an edge; model is updated from pre-edge state.
  task automatic bus_access(input string tag, input logic [7:0] addr, input logic [15:0] din,
                            input logic [1:0] wen, input logic rxv, input logic [15:0] rxd);
    logic sel, wr, rd, rxfull_pre;
    logic [15:0] exp_dout;
    logic [1:0] off;
    per_addr = addr; per_din = din; per_wen = wen; per_en = 1'b1;
    rx_valid = rxv; rx_data = rxd;
    sel = (addr[7:2] == BASE[7:2]);
    wr  = sel & (|wen);
    rd  = sel & ~(|wen);
    off = addr[1:0];
    exp_dout = 16'h0000;
    if (rd) begin
      case (off)
        2'd0: exp_dout = IRQ_EN ? {14'h0, rxie_m, txie_m} : 16'h0000;
        2'd1: exp_dout = exp_stat();
        2'd2: exp_dout = 16'h0000;
        default: exp_dout = (rx_q.size() != 0) ? rx_q[0] : 16'h0000;
      endcase
    end
    #1;
    if (!wr) check({tag, "_dout"}, per_dout, exp_dout);
    rxfull_pre = (rx_q.size() == DEPTH);
    if (wr && off == 2'd1 && wen[0]) begin
      if (din[4]) rxovf_m = 0;
      if (din[5]) txovf_m = 0;
    end
    if (wr && off == 2'd0 && wen[0]) begin
      txie_m = din[0]; rxie_m = din[1];
    end
    if (wr && off == 2'd0 && wen[0] && din[2]) tx_q.delete();
    else if (wr && off == 2'd2) begin
      if (tx_q.size() < DEPTH) tx_q.push_back({wen[1] ? din[15:8] : 8'h00, wen[0] ? din[7:0] : 8'h00});
      else txovf_m = 1;
    end
    if (wr && off == 2'd0 && wen[0] && din[3]) rx_q.delete();
    else begin
      if (rd && off == 2'd3 && rx_q.size() != 0) void'(rx_q.pop_front());
      if (rxv) begin
        if (!rxfull_pre) rx_q.push_back(rxd);
        else rxovf_m = 1;
      end
    end
    @(posedge mclk); #1;
    per_en = 1'b0; per_wen = 2'b00; rx_valid = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [15:0] din, input logic [1:0] wen);
    bus_access("wr", addr, din, wen, 1'b0, 16'h0000);
  endtask

  task automatic rd_reg(input string tag, input logic [7:0] addr);
    bus_access(tag, addr, 16'h0000, 2'b00, 1'b0, 16'h0000);
  endtask

  task automatic rx_push(input logic [15:0] d);
    bus_access("rxp", 8'h00, 16'h0000, 2'b00, 1'b1, d);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_txv"}, {15'h0, tx_valid}, {15'h0, tx_q.size() != 0});
    check({tag, "_txd"}, tx_data, (tx_q.size() != 0) ? tx_q[0] : 16'h0000);
    check({tag, "_irq"}, {15'h0, irq_fifo}, {15'h0, exp_irq()});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge mclk);
    #1;
    check("rst_txv", {15'h0, tx_valid}, 16'h0000);
    check("rst_txd", tx_data, 16'h0000);
    check("rst_irq", {15'h0, irq_fifo}, 16'h0000);
    check("rst_dout", per_dout, 16'h0000);
    puc = 1'b0;
    @(posedge mclk); #1;

    rd_reg("stat0", BASE + 8'd1);
    rd_reg("unsel", 8'h50);

    wr_reg(BASE + 8'd2, 16'h1234, 2'b01);
    check_state("tx1");
    rd_reg("stat1", BASE + 8'd1);

    wr_reg(BASE + 8'd2, 16'hBEEF, 2'b11);
    wr_reg(BASE + 8'd2, 16'hCAFE, 2'b10);
    wr_reg(BASE + 8'd2, 16'h0101, 2'b11);
    wr_reg(BASE + 8'd2, 16'h7777, 2'b11);
    rd_reg("stat_full", BASE + 8'd1);
    rd_reg("txdata_rd", BASE + 8'd2);
    wr_reg(BASE + 8'd1, 16'h0020, 2'b01);
    rd_reg("stat_clr", BASE + 8'd1);

    wr_reg(BASE + 8'd0, 16'h0001, 2'b01);
    check_state("txie_busy");
    tx_ready = 1'b1;
    repeat (6) @(posedge mclk);
    #1 tx_ready = 1'b0;
    check_state("drained");
    rd_reg("ctrl_rd", BASE + 8'd0);

    // Simultaneous CPU push and stream pop on a one-entry TX FIFO.
    wr_reg(BASE + 8'd2, 16'h1111, 2'b11);
    tx_ready = 1'b1;
    wr_reg(BASE + 8'd2, 16'h2222, 2'b11);
    tx_ready = 1'b0;
    check_state("tx_pushpop");
    rd_reg("stat_pp", BASE + 8'd1);
    wr_reg(BASE + 8'd2, 16'h3333, 2'b11);
    wr_reg(BASE + 8'd0, 16'h0004, 2'b01);
    check_state("txflush");
    rd_reg("stat_txfl", BASE + 8'd1);

    rx_push(16'hA5A5);
    rx_push(16'h5A5A);
    rd_reg("rx_a", BASE + 8'd3);
    rd_reg("rx_b", BASE + 8'd3);
    rd_reg("rx_empty", BASE + 8'd3);
    rd_reg("stat_rxe", BASE + 8'd1);

    rx_push(16'h0001);
    bus_access("rx_pp", BASE + 8'd3, 16'h0000, 2'b00, 1'b1, 16'h0002);
    rd_reg("stat_rxpp", BASE + 8'd1);
    for (int i = 0; i < 3; i++) rx_push(16'h0010 + 16'(i));
    bus_access("rx_fullpp", BASE + 8'd3, 16'h0000, 2'b00, 1'b1, 16'h00FF);
    rx_push(16'h00EE);
    rd_reg("stat_rxovf", BASE + 8'd1);
    wr_reg(BASE + 8'd1, 16'h0010, 2'b01);
    for (int i = 0; i < 5; i++) rd_reg("rx_drain", BASE + 8'd3);
    rd_reg("stat_rxdr", BASE + 8'd1);

    wr_reg(BASE + 8'd0, 16'h0002, 2'b01);
    check_state("rxie_idle");
    rx_push(16'hBEAD);
    check_state("rxie_irq");
    bus_access("rxflush", BASE + 8'd0, 16'h000A, 2'b01, 1'b1, 16'h1357);
    check_state("rxflush");
    rd_reg("stat_rxfl", BASE + 8'd1);
    for (int i = 0; i < DEPTH; i++) rx_push(16'h4000 + 16'(i));
    bus_access("rxflush_full", BASE + 8'd0, 16'h000A, 2'b01, 1'b1, 16'h2468);
    rd_reg("stat_rxflf", BASE + 8'd1);
    wr_reg(BASE + 8'd0, 16'hFF00, 2'b10);
    rd_reg("ctrl_hi", BASE + 8'd0);

    for (int i = 0; i < 3; i++) wr_reg(BASE + 8'd2, 16'h9000 + 16'(i), 2'b11);
    check_state("pre_rst");
    puc = 1'b1;
    tx_ready = 1'b1;
    #1;
    check("rst_mid_txv", {15'h0, tx_valid}, 16'h0000);
    check("rst_mid_txd", tx_data, 16'h0000);
    tx_q.delete(); rx_q.delete();
    txovf_m = 0; rxovf_m = 0; txie_m = 0; rxie_m = 0;
    @(posedge mclk); #1;
    puc = 1'b0;
    tx_ready = 1'b0;
    @(posedge mclk); #1;
    rd_reg("stat_rst", BASE + 8'd1);
    check_state("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
